// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: clocked vending transaction controller.
// One purchase at a time: lane/qty selection with stock check, coin
// accumulation, cancel/timeout refund, change, per-lane stock decrement and
// cumulative takings. Owns the stock registers (restock through a write port).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   tick_1s                    one-cycle strobe per second (PAY timeout)
//   sel_lane, sel_qty, confirm purchase request (lanes 1..NUM_LANES)
//   cancel                     abort purchase in PAY
//   coin_valid, coin_code      coin strobe, 001=1, 010=2, 100=5
//   restock_we/lane/qty        stock top-up, honoured in IDLE only
//   stock_flat                 all lane stock counts, lane 1 in LSB field
//   due, paid, change, gain    transaction amounts and cumulative takings
//   busy                       high in PAY, VEND, REFUND
//   vend_done, refund_done     one-cycle completion pulses
//   sel_err                    one-cycle pulse on rejected confirm
module vend_txn_ctrl #(
   parameter int NUM_LANES = 7,
   parameter int LANE_W = 3,
   parameter int STOCK_W = 3,
   parameter int QTY_W = 3,
   parameter int PRICE_W = 4,
   parameter logic [NUM_LANES*PRICE_W-1:0] PRICES =
      {4'd7, 4'd5, 4'd5, 4'd4, 4'd3, 4'd3, 4'd2},
   parameter int INIT_STOCK = 5,
   parameter int SUM_W = 7,
   parameter int GAIN_W = 10,
   parameter int TIMEOUT_S = 30
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         tick_1s,
   input  logic [LANE_W-1:0]            sel_lane,
   input  logic [QTY_W-1:0]             sel_qty,
   input  logic                         confirm,
   input  logic                         cancel,
   input  logic                         coin_valid,
   input  logic [2:0]                   coin_code,
   input  logic                         restock_we,
   input  logic [LANE_W-1:0]            restock_lane,
   input  logic [STOCK_W-1:0]           restock_qty,
   output logic [NUM_LANES*STOCK_W-1:0] stock_flat,
   output logic [SUM_W-1:0]             due,
   output logic [SUM_W-1:0]             paid,
   output logic [SUM_W-1:0]             change,
   output logic [GAIN_W-1:0]            gain,
   output logic                         busy,
   output logic                         vend_done,
   output logic                         refund_done,
   output logic                         sel_err
);

   localparam int DUE_W = PRICE_W + QTY_W;
   localparam int TMR_W = $clog2(TIMEOUT_S + 1);

   generate
      if (SUM_W < DUE_W) begin : g_sum_w_check
         $error("vend_txn_ctrl: SUM_W must be >= PRICE_W+QTY_W");
      end
      if ((2 ** LANE_W) <= NUM_LANES) begin : g_lane_w_check
         $error("vend_txn_ctrl: LANE_W too narrow for NUM_LANES");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_PAY, S_VEND, S_REFUND} state_t;

   state_t               state_q, state_d;
   logic [LANE_W-1:0]    lane_q;
   logic [QTY_W-1:0]     qty_q;
   logic [SUM_W-1:0]     due_q, paid_q, change_q;
   logic [GAIN_W-1:0]    gain_q;
   logic [TMR_W-1:0]     timer_q;
   logic [STOCK_W-1:0]   stock_q [NUM_LANES];
   logic                 busy_q, vend_q, refund_q, selerr_q;

   logic                 lane_ok, accept, coin_ok, timeout;
   logic [STOCK_W-1:0]   sel_stock;
   logic [PRICE_W-1:0]   sel_price;
   logic [DUE_W-1:0]     due_calc;
   logic [2:0]           coin_amt;
   logic [SUM_W-1:0]     paid_next;

   function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] a,
                                                    input logic [2:0] b);
      logic [SUM_W:0] s;
      s = {1'b0, a} + (SUM_W+1)'(b);
      return s[SUM_W] ? '1 : s[SUM_W-1:0];
   endfunction

   function automatic logic [STOCK_W-1:0] sat_add_stock(input logic [STOCK_W-1:0] a,
                                                        input logic [STOCK_W-1:0] b);
      logic [STOCK_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[STOCK_W] ? '1 : s[STOCK_W-1:0];
   endfunction

   function automatic logic [GAIN_W-1:0] sat_add_gain(input logic [GAIN_W-1:0] a,
                                                      input logic [SUM_W-1:0] b);
      logic [GAIN_W:0] s;
      s = {1'b0, a} + (GAIN_W+1)'(b);
      return s[GAIN_W] ? '1 : s[GAIN_W-1:0];
   endfunction

   // Lane decode: lane 0 and lanes above NUM_LANES match nothing.
   always_comb begin
      lane_ok   = 1'b0;
      sel_stock = '0;
      sel_price = '0;
      for (int i = 1; i <= NUM_LANES; i++) begin
         if (sel_lane == LANE_W'(i)) begin
            lane_ok   = 1'b1;
            sel_stock = stock_q[i-1];
            sel_price = PRICES[i*PRICE_W-1 -: PRICE_W];
         end
      end
      due_calc = DUE_W'(sel_price) * DUE_W'(sel_qty);
      // Stock check uses the registered (pre-restock) count.
      accept = (state_q == S_IDLE) && confirm && lane_ok && (sel_qty != '0) &&
               (32'(sel_qty) <= 32'(sel_stock));
   end

   always_comb begin
      case (coin_code)
         3'b001:  coin_amt = 3'd1;
         3'b010:  coin_amt = 3'd2;
         3'b100:  coin_amt = 3'd5;
         default: coin_amt = 3'd0;
      endcase
      coin_ok   = coin_valid && (coin_amt != 3'd0);
      paid_next = coin_ok ? sat_add_sum(paid_q, coin_amt) : paid_q;
      // A valid coin is activity, so it never coincides with a timeout.
      timeout   = !coin_ok && tick_1s && (timer_q == TMR_W'(TIMEOUT_S - 1));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_PAY;
         S_PAY: begin
            // Payment completion wins over cancel and timeout.
            if (paid_next >= due_q)  state_d = S_VEND;
            else if (cancel)         state_d = S_REFUND;
            else if (timeout)        state_d = S_REFUND;
         end
         S_VEND:   state_d = S_IDLE;
         S_REFUND: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         lane_q   <= '0;
         qty_q    <= '0;
         due_q    <= '0;
         paid_q   <= '0;
         change_q <= '0;
         gain_q   <= '0;
         timer_q  <= '0;
         busy_q   <= 1'b0;
         vend_q   <= 1'b0;
         refund_q <= 1'b0;
         selerr_q <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
      end else begin
         state_q  <= state_d;
         busy_q   <= (state_d != S_IDLE);
         vend_q   <= 1'b0;
         refund_q <= 1'b0;
         selerr_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  lane_q   <= sel_lane;
                  qty_q    <= sel_qty;
                  due_q    <= SUM_W'(due_calc);
                  paid_q   <= '0;
                  change_q <= '0;
                  timer_q  <= '0;
               end else if (confirm) begin
                  selerr_q <= 1'b1;
               end
               for (int i = 0; i < NUM_LANES; i++) begin
                  if (restock_we && (restock_lane == LANE_W'(i + 1)))
                     stock_q[i] <= sat_add_stock(stock_q[i], restock_qty);
               end
            end
            S_PAY: begin
               paid_q <= paid_next;
               if (coin_ok)      timer_q <= '0;
               else if (tick_1s) timer_q <= timer_q + TMR_W'(1);
            end
            S_VEND: begin
               for (int i = 0; i < NUM_LANES; i++) begin
                  if (lane_q == LANE_W'(i + 1))
                     stock_q[i] <= stock_q[i] - STOCK_W'(qty_q);
               end
               gain_q   <= sat_add_gain(gain_q, due_q);
               change_q <= paid_q - due_q;
               vend_q   <= 1'b1;
            end
            S_REFUND: begin
               change_q <= paid_q;
               refund_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stock_flat = '0;
      for (int i = 0; i < NUM_LANES; i++) stock_flat[i*STOCK_W +: STOCK_W] = stock_q[i];
   end

   assign due         = due_q;
   assign paid        = paid_q;
   assign change      = change_q;
   assign gain        = gain_q;
   assign busy        = busy_q;
   assign vend_done   = vend_q;
   assign refund_done = refund_q;
   assign sel_err     = selerr_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Testbench for vend_txn_ctrl: directed purchase scenarios checked every
// cycle against a transaction-level model, plus literal spot checks.
module tb_vend_txn_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick_1s = 1'b0;
   logic [2:0]  sel_lane = '0;
   logic [2:0]  sel_qty = '0;
   logic        confirm = 1'b0;
   logic        cancel = 1'b0;
   logic        coin_valid = 1'b0;
   logic [2:0]  coin_code = '0;
   logic        restock_we = 1'b0;
   logic [2:0]  restock_lane = '0;
   logic [2:0]  restock_qty = '0;
   logic [20:0] stock_flat;
   logic [6:0]  due, paid, change;
   logic [9:0]  gain;
   logic        busy, vend_done, refund_done, sel_err;

   int total = 0;
   int bad = 0;
   bit cmp_en = 1'b0;

   vend_txn_ctrl dut (
      .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s),
      .sel_lane(sel_lane), .sel_qty(sel_qty), .confirm(confirm), .cancel(cancel),
      .coin_valid(coin_valid), .coin_code(coin_code),
      .restock_we(restock_we), .restock_lane(restock_lane), .restock_qty(restock_qty),
      .stock_flat(stock_flat), .due(due), .paid(paid), .change(change), .gain(gain),
      .busy(busy), .vend_done(vend_done), .refund_done(refund_done), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: a purchase is "open" from acceptance until its
   // finishing cycle; 'finish' records how it will close (1 sale, 2 refund).
   int price_tab [8] = '{0, 2, 3, 3, 4, 5, 5, 7};
   int m_stock [8];
   int m_due, m_paid, m_change, m_gain, m_lane, m_qty, m_secs, finish;
   bit m_open, m_vend, m_ref, m_err;

   function automatic int coin_value(input logic v, input logic [2:0] c);
      if (!v) return 0;
      if (c == 3'b001) return 1;
      if (c == 3'b010) return 2;
      if (c == 3'b100) return 5;
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_stock[i] = 5;
      m_due = 0; m_paid = 0; m_change = 0; m_gain = 0;
      m_lane = 0; m_qty = 0; m_secs = 0; finish = 0;
      m_open = 0; m_vend = 0; m_ref = 0; m_err = 0;
   endtask

   task automatic model_step();
      int cv;
      m_vend = 0; m_ref = 0; m_err = 0;
      if (finish == 1) begin
         m_stock[m_lane] = m_stock[m_lane] - m_qty;
         m_gain = (m_gain + m_due > 1023) ? 1023 : m_gain + m_due;
         m_change = m_paid - m_due;
         m_vend = 1; m_open = 0; finish = 0;
      end else if (finish == 2) begin
         m_change = m_paid;
         m_ref = 1; m_open = 0; finish = 0;
      end else if (m_open) begin
         cv = coin_value(coin_valid, coin_code);
         if (cv > 0) m_paid = (m_paid + cv > 127) ? 127 : m_paid + cv;
         if (m_paid >= m_due) finish = 1;
         else if (cancel) finish = 2;
         else if (cv == 0 && tick_1s && m_secs == 29) finish = 2;
         if (cv > 0) m_secs = 0;
         else if (tick_1s) m_secs = m_secs + 1;
      end else begin
         if (confirm) begin
            if (sel_lane >= 1 && sel_lane <= 7 && sel_qty >= 1 &&
                int'(sel_qty) <= m_stock[sel_lane]) begin
               m_open = 1; m_lane = int'(sel_lane); m_qty = int'(sel_qty);
               m_due = price_tab[sel_lane] * m_qty;
               m_paid = 0; m_change = 0; m_secs = 0;
            end else begin
               m_err = 1;
            end
         end
         if (restock_we && restock_lane >= 1 && restock_lane <= 7)
            m_stock[restock_lane] = (m_stock[restock_lane] + int'(restock_qty) > 7) ? 7 :
                                    m_stock[restock_lane] + int'(restock_qty);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         logic [20:0] ef;
         ef = '0;
         for (int i = 1; i <= 7; i++) ef[(i-1)*3 +: 3] = 3'(m_stock[i]);
         check("stock_flat", int'(stock_flat), int'(ef));
         check("due", int'(due), m_due);
         check("paid", int'(paid), m_paid);
         check("change", int'(change), m_change);
         check("gain", int'(gain), m_gain);
         check("busy", int'(busy), int'(m_open || finish != 0));
         check("vend_done", int'(vend_done), int'(m_vend));
         check("refund_done", int'(refund_done), int'(m_ref));
         check("sel_err", int'(sel_err), int'(m_err));
      end
   end

   // Apply one cycle of inputs (called just after a falling edge).
   task automatic cyc(input bit cf, input int ln, input int qt, input bit cn,
                      input int coin, input bit tk, input bit rw, input int rl, input int rq);
      confirm = cf; sel_lane = 3'(ln); sel_qty = 3'(qt); cancel = cn;
      coin_valid = (coin != 0); coin_code = 3'(coin); tick_1s = tk;
      restock_we = rw; restock_lane = 3'(rl); restock_qty = 3'(rq);
      @(negedge clk);
      confirm = 0; cancel = 0; coin_valid = 0; coin_code = '0;
      tick_1s = 0; restock_we = 0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [20:0] all5;
      all5 = {7{3'b101}};
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // Reset state
      check("rst_stock", int'(stock_flat), int'(all5));
      check("rst_busy", int'(busy), 0);
      check("rst_gain", int'(gain), 0);

      // 1: lane 4 qty 2, due 8, coins 5 + 5
      cyc(1, 4, 2, 0, 0, 0, 0, 0, 0);
      check("t1_due", int'(due), 8);
      check("t1_busy", int'(busy), 1);
      cyc(0, 0, 0, 0, 3'b100, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 3'b100, 0, 0, 0, 0);
      check("t1_paid", int'(paid), 10);
      check("t1_vend_early", int'(vend_done), 0);
      idle(1);
      check("t1_vend_done", int'(vend_done), 1);
      check("t1_change", int'(change), 2);
      check("t1_gain", int'(gain), 8);
      check("t1_stock4", int'(stock_flat[11:9]), 3);
      idle(1);
      check("t1_vend_pulse", int'(vend_done), 0);
      check("t1_change_hold", int'(change), 2);

      // 2: rejected selections
      do_reset();
      cyc(1, 7, 6, 0, 0, 0, 0, 0, 0);
      check("t2_err_qty", int'(sel_err), 1);
      check("t2_busy", int'(busy), 0);
      check("t2_due", int'(due), 0);
      cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
      check("t2_err_lane0", int'(sel_err), 1);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      check("t2_err_qty0", int'(sel_err), 1);
      idle(1);
      check("t2_err_pulse", int'(sel_err), 0);

      // 3: timeout refund; an invalid coin code does not restart the timer
      cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
      check("t3_due", int'(due), 2);
      cyc(0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
      for (int k = 1; k <= 29; k++) cyc(0, 0, 0, 0, (k == 10) ? 3 : 0, 1, 0, 0, 0);
      check("t3_still_pay", int'(busy), 1);
      cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
      check("t3_refund_early", int'(refund_done), 0);
      idle(1);
      check("t3_refund_done", int'(refund_done), 1);
      check("t3_change", int'(change), 1);
      check("t3_stock1", int'(stock_flat[2:0]), 5);
      check("t3_gain", int'(gain), 0);
      check("t3_busy", int'(busy), 0);

      // 4: completing coin together with cancel -> sale
      cyc(1, 2, 1, 0, 0, 0, 0, 0, 0);
      check("t4_due", int'(due), 3);
      cyc(0, 0, 0, 0, 3'b001, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 3'b010, 0, 0, 0, 0);
      idle(1);
      check("t4_vend_done", int'(vend_done), 1);
      check("t4_refund", int'(refund_done), 0);
      check("t4_change", int'(change), 0);
      check("t4_gain", int'(gain), 3);
      idle(1);

      // 5: restock saturation; restock+confirm same cycle; restock during PAY
      cyc(0, 0, 0, 0, 0, 0, 1, 3, 4);
      check("t5_stock3_sat", int'(stock_flat[8:6]), 7);
      cyc(1, 6, 6, 0, 0, 0, 1, 6, 2);
      check("t5_pre_restock_err", int'(sel_err), 1);
      check("t5_stock6", int'(stock_flat[17:15]), 7);
      cyc(1, 7, 1, 0, 0, 0, 0, 0, 0);
      check("t5_due7", int'(due), 7);
      cyc(0, 0, 0, 0, 0, 0, 1, 5, 1);
      check("t5_stock5_pay", int'(stock_flat[14:12]), 5);
      cyc(1, 1, 1, 0, 3'b010, 0, 0, 0, 0);
      check("t5_confirm_busy", int'(sel_err), 0);
      cyc(0, 0, 0, 0, 3'b010, 0, 0, 0, 0);
      check("t6_paid4", int'(paid), 4);

      // 6: asynchronous reset mid-PAY
      rst_n = 1'b0;
      #1;
      check("t6_stock", int'(stock_flat), int'(all5));
      check("t6_paid", int'(paid), 0);
      check("t6_busy", int'(busy), 0);
      check("t6_refund", int'(refund_done), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      check("t6_no_refund", int'(refund_done), 0);
      check("t6_no_vend", int'(vend_done), 0);

      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
